rcs_jet_driver: RTL and testbench
=================================

// Module: rcs_jet_driver
// PURPOSE
//  Downstream of the channel 05/06 output logic. Takes the 16 RCS jet-command levels
//  (RCpXpP..RCmZpR) and produces the jet solenoid drive lines.
//  Enforces a minimum on-time and a minimum off-time per jet. A global inhibit forces
//  every jet off. Keeps a saturating firing counter per jet for test readback.
// PARAMETERS
//  MIN_ON   16  minimum drive-on duration, in CLOCK cycles (>=1)
//  MIN_OFF  8   minimum drive-off duration after any turn-off, in CLOCK cycles (>=1)
//  TW       8   per-jet timer width; must satisfy MIN_ON, MIN_OFF <= 2**TW
// PORTS
//  CLOCK     in   1   system clock
//  rst       in   1   reset; synchronous, active-high
//  JET_CMD   in   16  jet command levels, active-high, bit mapping:
//                     0 RCpXpP, 1 RCmXmP, 2 RCpXmP, 3 RCmXpP, 4 RCpZpR, 5 RCmZmR,
//                     6 RCpYpR, 7 RCmYmR, 8 RCpXpY, 9 RCmXmY, 10 RCpXmY, 11 RCmXpY,
//                     12 RCpYmR, 13 RCmYpR, 14 RCpZmR, 15 RCmZpR
//  JET_INH   in   1   global inhibit, e.g. driven from GOJAM; active-high
//  CNT_CLR   in   1   clears all 16 firing counters
//  FIRE_SEL  in   4   selects which jet's counter appears on FIRE_CNT
//  JET_OUT   out  16  solenoid drive, registered, same bit mapping as JET_CMD
//  FIRE_CNT  out  8   firing count of the jet selected by FIRE_SEL (combinational mux)
// BEHAVIOUR
//  Reset (rst high at a CLOCK edge):
//   - every jet goes to OFF, timers 0, counters 0
//   - JET_OUT = 16'h0000; FIRE_CNT reads 0
//  Each jet has an independent 3-state FSM: OFF, ON, HOLDOFF.
//  JET_OUT[i] = 1 exactly when jet i is in state ON.
//   - OFF:
//     - JET_CMD[i]=1 and JET_INH=0 -> ON, timer <= MIN_ON-1, counter[i] += 1
//     - latency: JET_OUT rises on the first edge that samples CMD high (1 cycle)
//   - ON:
//     - JET_INH=1 -> HOLDOFF immediately, timer <= MIN_OFF-1. Inhibit overrides MIN_ON.
//     - else timer != 0 -> timer decrements; the jet stays ON regardless of CMD
//     - else timer == 0 and CMD=0 -> HOLDOFF, timer <= MIN_OFF-1
//     - else timer == 0 and CMD=1 -> remain ON (timer holds at 0); counter not incremented
//     - result: a 1-cycle command pulse yields exactly MIN_ON cycles of JET_OUT high
//   - HOLDOFF:
//     - timer != 0 -> decrement; CMD is ignored
//     - timer == 0 -> OFF
//     - if CMD is still high, the next edge re-enters ON (OFF->ON check applies),
//       so the minimum low gap is MIN_OFF+1 cycles
//  JET_INH=1 holds every jet out of ON:
//   - OFF jets stay OFF
//   - ON jets go to HOLDOFF
//   - HOLDOFF jets continue counting down
//  No interlock between opposing jets. Conflicting commands pass through; that is
//  upstream's responsibility.
//  Counters: 8-bit, saturate at 255 (no wrap).
//   - CNT_CLR=1 zeroes all counters on that edge
//   - CNT_CLR and an increment on the same edge -> counter = 0 (clear wins)
//  rst mid-pulse: JET_OUT drops on that edge, with no MIN_ON honoured.
//  On the first edge after rst is released, a high CMD fires again (counter = 1).
//  Simultaneous events on different jets are fully independent; no arbitration.
// TESTING
//  1 Reset release:
//    rst high 3 cycles, CMD=16'hFFFF -> JET_OUT=0 throughout.
//    After release, JET_OUT=16'hFFFF one cycle later, and every counter = 1.
//  2 Minimum on:
//    1-cycle pulse on CMD[0] -> JET_OUT[0] high for exactly 16 cycles, then low
//    for >=8 cycles; FIRE_SEL=0 -> FIRE_CNT=1.
//  3 Minimum off:
//    CMD[5] high 20 cycles, low 2, high again -> JET_OUT[5] high 20, low 9, high again;
//    FIRE_SEL=5 -> FIRE_CNT=2.
//  4 Inhibit:
//    JET_INH asserted 4 cycles into a CMD[12] pulse -> JET_OUT[12] low on that edge.
//    No refire while INH=1 even with CMD held high.
//    Refire after INH clears and HOLDOFF expires.
//  5 Saturation and clear:
//    300 separate pulses on CMD[15] -> FIRE_CNT=255 at FIRE_SEL=15.
//    CNT_CLR coincident with a new fire -> FIRE_CNT=0.
//  6 Independence:
//    staggered pulses on jets 3 and 8 -> each JET_OUT bit is timed independently;
//    the other 14 bits stay 0.

Source files
------------

// File: rtl/rcs_jet_driver.sv
// rcs_jet_driver: per-jet solenoid drive with minimum on/off times, global inhibit and firing counters
module rcs_jet_driver #(
  parameter int MIN_ON  = 16,
  parameter int MIN_OFF = 8,
  parameter int TW      = 8
) (
  input  logic        CLOCK,
  input  logic        rst,
  input  logic [15:0] JET_CMD,
  input  logic        JET_INH,
  input  logic        CNT_CLR,
  input  logic [3:0]  FIRE_SEL,
  output logic [15:0] JET_OUT,
  output logic [7:0]  FIRE_CNT
);
  typedef enum logic [1:0] {OFF, ON, HOLD} state_e;
  logic [15:0][7:0] cnt_all;
  genvar i;
  for (i = 0; i < 16; i++) begin : g_jet
    state_e        st_q, st_d;
    logic [TW-1:0] tm_q, tm_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          fire, stop;
    always_comb begin
      fire  = st_q == OFF && JET_CMD[i] && !JET_INH;
      // inhibit cuts a firing short; otherwise turn-off waits for the on-timer to expire
      stop  = st_q == ON && (JET_INH || (tm_q == '0 && !JET_CMD[i]));
      st_d  = fire ? ON : stop ? HOLD : (st_q == HOLD && tm_q == '0) ? OFF : st_q;
      tm_d  = fire ? TW'(MIN_ON - 1) : stop ? TW'(MIN_OFF - 1) : tm_q != '0 ? tm_q - TW'(1) : tm_q;
      cnt_d = CNT_CLR ? 8'd0 : (fire && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end
    always_ff @(posedge CLOCK) begin
      if (rst) begin
        st_q  <= OFF;
        tm_q  <= '0;
        cnt_q <= 8'd0;
      end else begin
        st_q  <= st_d;
        tm_q  <= tm_d;
        cnt_q <= cnt_d;
      end
    end
    assign JET_OUT[i] = st_q == ON;
    assign cnt_all[i] = cnt_q;
  end
  assign FIRE_CNT = cnt_all[FIRE_SEL];
endmodule

// File: tb/tb_rcs_jet_driver.sv
// tb_rcs_jet_driver: directed checks of min-on/min-off timing, inhibit, counters and independence
module tb_rcs_jet_driver;
  logic        CLOCK = 0;
  logic        rst = 1;
  logic [15:0] JET_CMD = '0;
  logic        JET_INH = 0;
  logic        CNT_CLR = 0;
  logic [3:0]  FIRE_SEL = '0;
  logic [15:0] JET_OUT;
  logic [7:0]  FIRE_CNT;
  int checks = 0;
  int errors = 0;

  rcs_jet_driver dut (
    .CLOCK(CLOCK), .rst(rst), .JET_CMD(JET_CMD), .JET_INH(JET_INH),
    .CNT_CLR(CNT_CLR), .FIRE_SEL(FIRE_SEL), .JET_OUT(JET_OUT), .FIRE_CNT(FIRE_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] sel, input logic [7:0] exp);
    FIRE_SEL = sel;
    #1;
    chk(tag, {8'h00, FIRE_CNT}, {8'h00, exp});
  endtask

  initial begin
    // 1 reset release
    JET_CMD = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("rst_out", JET_OUT, 16'h0000);
    end
    chk_cnt("rst_cnt", 4'd7, 8'd0);
    rst = 0;
    step(1);
    chk("release_out", JET_OUT, 16'hFFFF);
    for (int j = 0; j < 16; j++) chk_cnt("release_cnt", 4'(j), 8'd1);
    JET_CMD = '0;
    step(30);
    chk("drain1", JET_OUT, 16'h0000);
    CNT_CLR = 1;
    step(1);
    CNT_CLR = 0;
    chk_cnt("clr_cnt", 4'd9, 8'd0);

    // 2 minimum on-time from a 1-cycle pulse
    JET_CMD = 16'h0001;
    step(1);
    JET_CMD = '0;
    for (int k = 0; k < 16; k++) begin
      chk("minon_high", JET_OUT, 16'h0001);
      step(1);
    end
    for (int k = 0; k < 8; k++) begin
      chk("minon_low", JET_OUT, 16'h0000);
      step(1);
    end
    chk_cnt("minon_cnt", 4'd0, 8'd1);

    // 3 minimum off-time
    JET_CMD = 16'h0020;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("minoff_high", JET_OUT, 16'h0020);
    end
    JET_CMD = '0;
    for (int k = 0; k < 2; k++) begin
      step(1);
      chk("minoff_low_a", JET_OUT, 16'h0000);
    end
    JET_CMD = 16'h0020;
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk("minoff_low_b", JET_OUT, 16'h0000);
    end
    step(1);
    chk("minoff_refire", JET_OUT, 16'h0020);
    chk_cnt("minoff_cnt", 4'd5, 8'd2);
    JET_CMD = '0;
    step(30);

    // 4 inhibit
    JET_CMD = 16'h1000;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("inh_pre", JET_OUT, 16'h1000);
    end
    JET_INH = 1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("inh_held", JET_OUT, 16'h0000);
    end
    JET_INH = 0;
    step(1);
    chk("inh_refire", JET_OUT, 16'h1000);
    chk_cnt("inh_cnt", 4'd12, 8'd2);
    JET_CMD = '0;
    step(30);

    // reset in the middle of a firing
    JET_CMD = 16'h0002;
    step(3);
    chk("midrst_on", JET_OUT, 16'h0002);
    rst = 1;
    step(1);
    chk("midrst_off", JET_OUT, 16'h0000);
    rst = 0;
    step(1);
    chk("midrst_refire", JET_OUT, 16'h0002);
    chk_cnt("midrst_cnt", 4'd1, 8'd1);
    JET_CMD = '0;
    step(30);

    // 5 saturation and clear
    for (int p = 0; p < 300; p++) begin
      JET_CMD = 16'h8000;
      step(1);
      JET_CMD = '0;
      step(25);
    end
    chk_cnt("sat_cnt", 4'd15, 8'd255);
    CNT_CLR = 1;
    JET_CMD = 16'h8000;
    step(1);
    CNT_CLR = 0;
    JET_CMD = '0;
    chk("clrfire_out", JET_OUT, 16'h8000);
    chk_cnt("clrfire_cnt", 4'd15, 8'd0);
    step(30);

    // 6 independence of staggered jets
    JET_CMD = 16'h0008;
    step(1);
    chk("ind_e1", JET_OUT, 16'h0008);
    JET_CMD = 16'h0100;
    for (int k = 2; k <= 18; k++) begin
      step(1);
      JET_CMD = '0;
      chk("ind_seq", JET_OUT, {7'd0, k <= 17, 4'd0, k <= 16, 3'd0});
    end
    chk_cnt("ind_cnt3", 4'd3, 8'd1);
    chk_cnt("ind_cnt8", 4'd8, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
